gerador_tabela_verdade: RTL and testbench

//  Upstream stimulus/capture stage for the 3-input combinational circuits under test (a,b,c -> s1).
//  - Steps the input vector through all 2**N_IN combinations, holding each for a settle window.
//  - Samples s1 once per vector and assembles the measured truth table.
//  - Compares the table against an expected word and reports done/erro.

---
 rtl/tabela_pkg.sv | 14 +
 rtl/contador_espera.sv | 33 +++
 rtl/gerador_tabela_verdade.sv | 130 +++++++++++++
 tb/tb_gerador_tabela_verdade.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tabela_pkg.sv
// Shared types and defaults for the truth-table generator.
// Holds the FSM state type, parameter defaults and the vector-count helper.
package tabela_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} estado_t;

   localparam int unsigned N_IN_DEF          = 3;
   localparam int unsigned SETTLE_CYCLES_DEF = 4;

   function automatic int unsigned NVEC(input int unsigned n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Settle timer: counts cycles while load is low.
// expira flags the last settle cycle so the FSM samples on the following edge.
module contador_espera #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expira
);

   localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (load) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expira = (cnt_q == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gerador_tabela_verdade.sv
// Steps x through every input combination, samples s1 after a settle window and
// compares the measured truth table against the expected word latched at start.
module gerador_tabela_verdade
   import tabela_pkg::*;
#(
   parameter  int unsigned N_IN          = N_IN_DEF,
   parameter  int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   localparam int unsigned NV            = NVEC(N_IN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NV-1:0]   esperado,
   input  logic            s1,
   output logic [N_IN-1:0] x,
   output logic            busy,
   output logic            done,
   output logic [NV-1:0]   tabela,
   output logic [NV-1:0]   diff,
   output logic            erro
);

   if (SETTLE_CYCLES < 1) begin : g_settle_check
      $error("SETTLE_CYCLES must be >= 1");
   end

   estado_t         estado_q, estado_d;
   logic [N_IN-1:0] x_q, x_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [NV-1:0]   tabela_q, tabela_d;
   logic [NV-1:0]   diff_q, diff_d;
   logic            erro_q, erro_d;
   logic [NV-1:0]   esp_q, esp_d;
   logic [NV-1:0]   tab_amostra;
   logic            expira;

   // Timer is held cleared outside SETTLE so each vector starts a fresh window.
   contador_espera #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_contador_espera (
      .clk    (clk),
      .rst    (rst),
      .load   (estado_q != SETTLE),
      .expira (expira)
   );

   always_comb begin
      estado_d = estado_q;
      x_d      = x_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tabela_d = tabela_q;
      diff_d   = diff_q;
      erro_d   = erro_q;
      esp_d    = esp_q;

      tab_amostra        = tabela_q;
      tab_amostra[x_q]   = s1;

      unique case (estado_q)
         IDLE: begin
            if (start) begin
               esp_d    = esperado;
               x_d      = '0;
               tabela_d = '0;
               diff_d   = '0;
               erro_d   = 1'b0;
               busy_d   = 1'b1;
               estado_d = SETTLE;
            end
         end
         SETTLE: begin
            if (expira) begin
               estado_d = SAMPLE;
            end
         end
         SAMPLE: begin
            tabela_d = tab_amostra;
            if (x_q == '1) begin
               // Compare uses the table including the sample taken on this edge.
               busy_d   = 1'b0;
               diff_d   = tab_amostra ^ esp_q;
               erro_d   = |(tab_amostra ^ esp_q);
               done_d   = 1'b1;
               estado_d = DONE;
            end else begin
               x_d      = x_q + N_IN'(1);
               estado_d = SETTLE;
            end
         end
         DONE: begin
            estado_d = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= IDLE;
         x_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tabela_q <= '0;
         diff_q   <= '0;
         erro_q   <= 1'b0;
         esp_q    <= '0;
      end else begin
         estado_q <= estado_d;
         x_q      <= x_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         tabela_q <= tabela_d;
         diff_q   <= diff_d;
         erro_q   <= erro_d;
         esp_q    <= esp_d;
      end
   end

   assign x      = x_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign tabela = tabela_q;
   assign diff   = diff_q;
   assign erro   = erro_q;

endmodule

// File: tb/tb_gerador_tabela_verdade.sv
// Bench for gerador_tabela_verdade driving a behavioural s1 = (a&b)|c, plus a
// second small instance (N_IN=2, SETTLE_CYCLES=1) observing s1 = a^b.
module tb_gerador_tabela_verdade;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] esperado;
   logic       s1;
   logic [2:0] x;
   logic       busy, done, erro;
   logic [7:0] tabela, diff;

   logic       start2;
   logic [3:0] esp2, tabela2, diff2;
   logic [1:0] x2;
   logic       s1b, busy2, done2, erro2;

   logic glitch_en = 1'b0;
   logic rnd_bit   = 1'b0;

   always #5 clk = ~clk;

   assign s1  = glitch_en ? rnd_bit : ((x[2] & x[1]) | x[0]);
   assign s1b = x2[1] ^ x2[0];

   gerador_tabela_verdade dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .esperado (esperado),
      .s1       (s1),
      .x        (x),
      .busy     (busy),
      .done     (done),
      .tabela   (tabela),
      .diff     (diff),
      .erro     (erro)
   );

   gerador_tabela_verdade #(
      .N_IN          (2),
      .SETTLE_CYCLES (1)
   ) dut2 (
      .clk      (clk),
      .rst      (rst),
      .start    (start2),
      .esperado (esp2),
      .s1       (s1b),
      .x        (x2),
      .busy     (busy2),
      .done     (done2),
      .tabela   (tabela2),
      .diff     (diff2),
      .erro     (erro2)
   );

   typedef struct {
      logic [7:0] tab;
      logic [7:0] dif;
      logic       err;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] esp;
      logic [7:0] tab;
      logic [7:0] dif;
      logic       err;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[5];

   int n_chk    = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: each done pops the oldest expected scan result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_tabela", {24'd0, tabela}, {24'd0, mon_e.tab});
            chk("sb_diff", {24'd0, diff}, {24'd0, mon_e.dif});
            chk("sb_erro", {31'd0, erro}, {31'd0, mon_e.err});
            chk("sb_done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic start_scan(input vec_t v, output int acc);
      exp_t e;
      @(negedge clk);
      esperado = v.esp;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
      e.tab = v.tab;
      e.dif = v.dif;
      e.err = v.err;
      e.cyc = acc + 40;
      sb.push_back(e);
   endtask

   task automatic wait_sb(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (sb.size() != 0) begin
         chk(name, sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_x"}, {29'd0, x}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_tabela"}, {24'd0, tabela}, 32'd0);
      chk({tag, "_diff"}, {24'd0, diff}, 32'd0);
      chk({tag, "_erro"}, {31'd0, erro}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, n, d0;
      exp_t e;
      vec_t v_ok;

      vecs[0] = '{esp: 8'hEA, tab: 8'hEA, dif: 8'h00, err: 1'b0};
      vecs[1] = '{esp: 8'hEB, tab: 8'hEA, dif: 8'h01, err: 1'b1};
      vecs[2] = '{esp: 8'h00, tab: 8'hEA, dif: 8'hEA, err: 1'b1};
      vecs[3] = '{esp: 8'hFF, tab: 8'hEA, dif: 8'h15, err: 1'b1};
      vecs[4] = '{esp: 8'h6A, tab: 8'hEA, dif: 8'h80, err: 1'b1};
      v_ok    = vecs[0];

      rst      = 1'b1;
      start    = 1'b0;
      start2   = 1'b0;
      esperado = 8'h00;
      esp2     = 4'b0110;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // Table-driven scans; diff/erro must hold after done and clear on the next start.
      for (int i = 0; i < 5; i++) begin
         start_scan(vecs[i], acc);
         chk("start_busy", {31'd0, busy}, 32'd1);
         if (i > 0) begin
            chk("clear_diff", {24'd0, diff}, 32'd0);
            chk("clear_erro", {31'd0, erro}, 32'd0);
            chk("clear_tabela", {24'd0, tabela}, 32'd0);
         end
         if (i == 0) begin
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               chk("x_step", {29'd0, x}, c / 5);
            end
         end
         wait_sb("scan_timeout");
         repeat (3) @(negedge clk);
         chk("hold_diff", {24'd0, diff}, {24'd0, vecs[i].dif});
         chk("hold_erro", {31'd0, erro}, {31'd0, vecs[i].err});
         chk("hold_tabela", {24'd0, tabela}, {24'd0, vecs[i].tab});
         chk("hold_x", {29'd0, x}, 32'd7);
         chk("hold_busy", {31'd0, busy}, 32'd0);
      end

      // s1 glitches outside the sample cycles and start pulses while busy.
      d0 = done_cnt;
      start_scan(v_ok, acc);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         glitch_en = (c % 5 != 4);
         rnd_bit   = 1'($urandom);
         start     = (c == 10 || c == 23);
      end
      start     = 1'b0;
      @(negedge clk);
      glitch_en = 1'b0;
      wait_sb("glitch_timeout");
      repeat (50) @(negedge clk);
      chk("glitch_done_count", done_cnt - d0, 32'd1);
      chk("glitch_no_restart", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-scan while x==3, then a clean rescan.
      start_scan(v_ok, acc);
      n = 0;
      while (x !== 3'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_x3", {29'd0, x}, 32'd3);
      chk("partial_tabela", {24'd0, tabela}, 32'h02);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      start_scan(v_ok, acc);
      wait_sb("post_rst_timeout");

      // start held high: three back-to-back scans, period 42.
      @(negedge clk);
      esperado = 8'hEA;
      start    = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      for (int k = 0; k < 3; k++) begin
         e.tab = 8'hEA;
         e.dif = 8'h00;
         e.err = 1'b0;
         e.cyc = acc + 40 + 42 * k;
         sb.push_back(e);
      end
      for (int c = 0; c < 126; c++) begin
         @(negedge clk);
         chk("b2b_busy", {31'd0, busy}, ((c % 42 == 40) || (c % 42 == 41)) ? 32'd0 : 32'd1);
         if (c == 124) start = 1'b0;
      end
      wait_sb("b2b_timeout");

      // Small instance: 2 inputs, 2 cycles per vector.
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      acc    = cyc;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("small_x_step", {30'd0, x2}, c / 2);
      end
      n = 0;
      while (done2 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("small_done", {31'd0, done2}, 32'd1);
      chk("small_latency", cyc - acc, 32'd8);
      chk("small_tabela", {28'd0, tabela2}, 32'h6);
      chk("small_erro", {31'd0, erro2}, 32'd0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
